// File: rtl/fft_r2_stream_stage.sv
// Radix-2 DIF inter-block butterfly: sums 1 cycle after each pair beat, then differences drained from the delay buffer.
// No backpressure: input gaps via din_valid are tolerated, the drain never stalls, outputs are valid-only.
module fft_r2_stream_stage #(
   parameter int LANES = 16,
   parameter int DIN_W = 11,
   parameter int DIST = 16,
   parameter int SCALE = 0,
   localparam int DOUT_W = DIN_W + 1 - SCALE
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           din_valid,
   input  logic [LANES-1:0][DIN_W-1:0]    din_i,
   input  logic [LANES-1:0][DIN_W-1:0]    din_q,
   output logic                           valid_out,
   output logic [LANES-1:0][DOUT_W-1:0]   dout_i,
   output logic [LANES-1:0][DOUT_W-1:0]   dout_q,
   output logic                           dout_diff
);

   localparam int BW = DIN_W + 1;
   localparam int CNT_W = $clog2(2 * DIST);
   localparam int AW = (DIST > 1) ? $clog2(DIST) : 1;

   typedef struct packed {
      logic [LANES-1:0][BW-1:0] re;
      logic [LANES-1:0][BW-1:0] im;
   } cvec_t;

   cvec_t                      mem [DIST];
   cvec_t                      rd_dat;
   cvec_t                      wr_dat;
   cvec_t                      sum_dat;
   cvec_t                      din_ext;
   logic [CNT_W-1:0]           in_cnt;
   logic [AW-1:0]              drain_cnt;
   logic                       drain_act;
   logic                       bfly;
   logic                       frame_end;
   logic                       drain_last;
   logic [AW-1:0]              pair_addr;
   logic [AW-1:0]              rd_addr;
   logic [LANES-1:0][DOUT_W-1:0] out_i;
   logic [LANES-1:0][DOUT_W-1:0] out_q;

   // Round-half-up halving; the extra bit keeps x+1 exact before the shift.
   function automatic logic [DOUT_W-1:0] scale_f(input logic [BW-1:0] x);
      logic [BW:0] r;
      r = {x[BW-1], x} + (BW+1)'(SCALE);
      return DOUT_W'(r >> SCALE);
   endfunction

   // 2*DIST is a power of two, so the top counter bit is the phase and the rest is the pair address.
   assign bfly       = in_cnt[CNT_W-1];
   assign pair_addr  = (DIST == 1) ? '0 : AW'(in_cnt);
   assign frame_end  = din_valid && (&in_cnt);
   assign drain_last = (drain_cnt == AW'(DIST - 1));
   assign rd_addr    = drain_act ? drain_cnt : pair_addr;
   assign rd_dat     = mem[rd_addr];

   always_comb begin
      din_ext = '0;
      sum_dat = '0;
      wr_dat  = '0;
      out_i   = '0;
      out_q   = '0;
      for (int l = 0; l < LANES; l++) begin
         din_ext.re[l] = {din_i[l][DIN_W-1], din_i[l]};
         din_ext.im[l] = {din_q[l][DIN_W-1], din_q[l]};
         sum_dat.re[l] = rd_dat.re[l] + din_ext.re[l];
         sum_dat.im[l] = rd_dat.im[l] + din_ext.im[l];
         wr_dat.re[l]  = bfly ? (rd_dat.re[l] - din_ext.re[l]) : din_ext.re[l];
         wr_dat.im[l]  = bfly ? (rd_dat.im[l] - din_ext.im[l]) : din_ext.im[l];
         out_i[l]      = scale_f(drain_act ? rd_dat.re[l] : sum_dat.re[l]);
         out_q[l]      = scale_f(drain_act ? rd_dat.im[l] : sum_dat.im[l]);
      end
   end

   // Read-before-write: a fill beat landing on the address the drain reads this cycle is safe.
   always_ff @(posedge clk) begin
      if (din_valid) begin
         mem[pair_addr] <= wr_dat;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         in_cnt    <= '0;
         drain_act <= 1'b0;
         drain_cnt <= '0;
      end else begin
         if (din_valid) begin
            in_cnt <= in_cnt + 1'b1;
         end
         if (drain_act) begin
            drain_cnt <= drain_cnt + 1'b1;
            if (drain_last) begin
               drain_act <= 1'b0;
            end
         end
         if (frame_end) begin
            drain_act <= 1'b1;
            drain_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_out <= 1'b0;
         dout_diff <= 1'b0;
         dout_i    <= '0;
         dout_q    <= '0;
      end else if (drain_act) begin
         valid_out <= 1'b1;
         dout_diff <= 1'b1;
         dout_i    <= out_i;
         dout_q    <= out_q;
      end else if (din_valid && bfly) begin
         valid_out <= 1'b1;
         dout_diff <= 1'b0;
         dout_i    <= out_i;
         dout_q    <= out_q;
      end else begin
         valid_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_r2_stream_stage.sv
// Directed bench for fft_r2_stream_stage: default, halving, and DIST=1/4-lane builds side by side.
module tb_fft_r2_stream_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rstn;
   logic                din_valid;
   logic [15:0][10:0]   din_i, din_q;
   logic                va, da, vb, db;
   logic [15:0][11:0]   ai, aq;
   logic [15:0][10:0]   bi, bq;
   logic                cvalid, vc, dc;
   logic [3:0][10:0]    cdi, cdq;
   logic [3:0][11:0]    ci, cq;

   fft_r2_stream_stage u_dut_a (
      .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
      .valid_out(va), .dout_i(ai), .dout_q(aq), .dout_diff(da));

   fft_r2_stream_stage #(.SCALE(1)) u_dut_b (
      .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_i(din_i), .din_q(din_q),
      .valid_out(vb), .dout_i(bi), .dout_q(bq), .dout_diff(db));

   fft_r2_stream_stage #(.LANES(4), .DIST(1)) u_dut_c (
      .clk(clk), .rstn(rstn), .din_valid(cvalid), .din_i(cdi), .din_q(cdq),
      .valid_out(vc), .dout_i(ci), .dout_q(cq), .dout_diff(dc));

   typedef struct {
      bit v;
      bit d;
      int i[16];
      int q[16];
   } rec_t;

   rec_t la[160];
   rec_t lb[160];
   rec_t lc[160];
   int   cyc;
   int   n_chk;
   int   n_fail;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (cyc < 160) begin
         la[cyc].v = va;
         la[cyc].d = da;
         lb[cyc].v = vb;
         lb[cyc].d = db;
         lc[cyc].v = vc;
         lc[cyc].d = dc;
         for (int j = 0; j < 16; j++) begin
            la[cyc].i[j] = $signed(ai[j]);
            la[cyc].q[j] = $signed(aq[j]);
            lb[cyc].i[j] = $signed(bi[j]);
            lb[cyc].q[j] = $signed(bq[j]);
         end
         for (int j = 0; j < 4; j++) begin
            lc[cyc].i[j] = $signed(ci[j]);
            lc[cyc].q[j] = $signed(cq[j]);
         end
      end
      cyc++;
   endtask

   task automatic drv(input bit v, input int i0, input int si, input int q0);
      din_valid = v;
      for (int j = 0; j < 16; j++) begin
         din_i[j] = 11'(i0 + si * j);
         din_q[j] = 11'(q0);
      end
      tick();
   endtask

   task automatic chk_rec(input string tag, input int t, input rec_t r, input bit ev, input bit ed,
                          input int ei, input int si, input int eq, input int nl);
      check($sformatf("%s_valid[%0d]", tag, t), r.v, ev);
      if (ev) begin
         check($sformatf("%s_diff[%0d]", tag, t), r.d, ed);
         for (int j = 0; j < nl; j++) begin
            check($sformatf("%s_i[%0d][%0d]", tag, t, j), r.i[j], ei + si * j);
            check($sformatf("%s_q[%0d][%0d]", tag, t, j), r.q[j], eq);
         end
      end
   endtask

   // Ramp frame (lane j, beat n: i=n*16+j): pair (n, n+16) sums to 32n+256+2j, differs by -256.
   task automatic chk_ramp(input string tag, input int base);
      for (int n = 0; n < 16; n++) begin
         chk_rec({tag, "_sum"}, base + n, la[base + n], 1'b1, 1'b0, 32 * n + 256, 2, 0, 16);
      end
      for (int n = 0; n < 16; n++) begin
         chk_rec({tag, "_dif"}, base + 16 + n, la[base + 16 + n], 1'b1, 1'b1, -256, 0, 0, 16);
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      cyc = 0;
      rstn = 1'b0;
      din_valid = 1'b0;
      din_i = '0;
      din_q = '0;
      cvalid = 1'b0;
      cdi = '0;
      cdq = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_a", va, 0);
      check("rst_diff_a", da, 0);
      check("rst_dout_i_a", $signed(ai[0]), 0);
      check("rst_dout_q_a", $signed(aq[15]), 0);
      check("rst_valid_c", vc, 0);
      check("rst_dout_i_c", $signed(ci[3]), 0);
      rstn = 1'b1;

      // Uniform frame: sums then diffs, both full precision and halved.
      cyc = 0;
      for (int n = 0; n < 16; n++) drv(1'b1, 100, 0, -20);
      for (int n = 0; n < 16; n++) drv(1'b1, 50, 0, 30);
      repeat (20) drv(1'b0, 0, 0, 0);
      for (int t = 0; t < 16; t++) chk_rec("t1_fill", t, la[t], 1'b0, 1'b0, 0, 0, 0, 16);
      for (int t = 16; t < 32; t++) begin
         chk_rec("t1a_sum", t, la[t], 1'b1, 1'b0, 150, 0, 10, 16);
         chk_rec("t1b_sum", t, lb[t], 1'b1, 1'b0, 75, 0, 5, 16);
      end
      for (int t = 32; t < 48; t++) begin
         chk_rec("t1a_dif", t, la[t], 1'b1, 1'b1, 50, 0, -50, 16);
         chk_rec("t1b_dif", t, lb[t], 1'b1, 1'b1, 25, 0, -25, 16);
      end
      chk_rec("t1_end", 48, la[48], 1'b0, 1'b0, 0, 0, 0, 16);
      check("t1_hold_i", la[48].i[0], 50);
      check("t1_hold_d", la[48].d, 1);

      // Extremes: lanes 0-7 a=1023, lanes 8-15 a=-1024, b=1023 everywhere.
      cyc = 0;
      for (int n = 0; n < 16; n++) begin
         din_valid = 1'b1;
         for (int j = 0; j < 16; j++) begin
            din_i[j] = 11'((j < 8) ? 1023 : -1024);
            din_q[j] = '0;
         end
         tick();
      end
      for (int n = 0; n < 16; n++) drv(1'b1, 1023, 0, 0);
      repeat (20) drv(1'b0, 0, 0, 0);
      for (int t = 16; t < 32; t++) begin
         check($sformatf("t2a_sum_hi[%0d]", t), la[t].i[0], 2046);
         check($sformatf("t2a_sum_lo[%0d]", t), la[t].i[8], -1);
         check($sformatf("t2b_sum_hi[%0d]", t), lb[t].i[0], 1023);
         check($sformatf("t2b_sum_lo[%0d]", t), lb[t].i[8], 0);
      end
      for (int t = 32; t < 48; t++) begin
         check($sformatf("t2a_dif_hi[%0d]", t), la[t].i[0], 0);
         check($sformatf("t2a_dif_lo[%0d]", t), la[t].i[8], -2047);
         check($sformatf("t2b_dif_hi[%0d]", t), lb[t].i[0], 0);
         check($sformatf("t2b_dif_lo[%0d]", t), lb[t].i[8], -1023);
         check($sformatf("t2a_dif_flag[%0d]", t), la[t].d, 1);
      end

      // Back-to-back ramp frames: 64 consecutive valid cycles.
      cyc = 0;
      for (int n = 0; n < 64; n++) drv(1'b1, (n % 32) * 16, 1, 0);
      repeat (20) drv(1'b0, 0, 0, 0);
      chk_rec("t3_pre", 15, la[15], 1'b0, 1'b0, 0, 0, 0, 16);
      chk_ramp("t3f1", 16);
      chk_ramp("t3f2", 48);
      chk_rec("t3_post", 80, la[80], 1'b0, 1'b0, 0, 0, 0, 16);

      // Half-rate frame, next frame starts on the first drain cycle.
      cyc = 0;
      for (int c = 0; c < 63; c++) begin
         if (c % 2 == 0) drv(1'b1, (c / 2) * 16, 1, 0);
         else drv(1'b0, 0, 0, 0);
      end
      for (int n = 0; n < 32; n++) drv(1'b1, n * 16, 1, 0);
      repeat (20) drv(1'b0, 0, 0, 0);
      chk_rec("t4_pre", 31, la[31], 1'b0, 1'b0, 0, 0, 0, 16);
      for (int n = 0; n < 16; n++) begin
         chk_rec("t4_sum", 32 + 2 * n, la[32 + 2 * n], 1'b1, 1'b0, 32 * n + 256, 2, 0, 16);
         if (n < 15) chk_rec("t4_gap", 33 + 2 * n, la[33 + 2 * n], 1'b0, 1'b0, 0, 0, 0, 16);
      end
      for (int k = 0; k < 16; k++) begin
         chk_rec("t4_dif", 63 + k, la[63 + k], 1'b1, 1'b1, -256, 0, 0, 16);
      end
      chk_ramp("t4f2", 79);
      chk_rec("t4_post", 111, la[111], 1'b0, 1'b0, 0, 0, 0, 16);

      // Reset during the sum phase, then a clean frame.
      cyc = 0;
      for (int n = 0; n < 21; n++) drv(1'b1, n * 16, 1, 0);
      for (int n = 0; n < 5; n++) begin
         chk_rec("t5_pre", 16 + n, la[16 + n], 1'b1, 1'b0, 32 * n + 256, 2, 0, 16);
      end
      din_valid = 1'b0;
      rstn = 1'b0;
      #1;
      check("t5_rst_valid", va, 0);
      check("t5_rst_diff", da, 0);
      check("t5_rst_dout", $signed(ai[0]), 0);
      @(posedge clk);
      #2;
      check("t5_rst_hold_valid", va, 0);
      rstn = 1'b1;
      cyc = 0;
      for (int n = 0; n < 32; n++) drv(1'b1, n * 16, 1, 0);
      repeat (20) drv(1'b0, 0, 0, 0);
      chk_rec("t5_fill", 15, la[15], 1'b0, 1'b0, 0, 0, 0, 16);
      chk_ramp("t5", 16);
      chk_rec("t5_post", 48, la[48], 1'b0, 1'b0, 0, 0, 0, 16);

      // DIST=1, 4 lanes: beat n lane j i=10n+j, q=-n; sum/diff alternate.
      cyc = 0;
      for (int n = 0; n < 8; n++) begin
         cvalid = 1'b1;
         for (int j = 0; j < 4; j++) begin
            cdi[j] = 11'(n * 10 + j);
            cdq[j] = 11'(-n);
         end
         tick();
      end
      cvalid = 1'b0;
      repeat (4) tick();
      chk_rec("t6_pre", 0, lc[0], 1'b0, 1'b0, 0, 0, 0, 4);
      for (int m = 0; m < 4; m++) begin
         chk_rec("t6_sum", 1 + 2 * m, lc[1 + 2 * m], 1'b1, 1'b0, 40 * m + 10, 2, -(4 * m + 1), 4);
         chk_rec("t6_dif", 2 + 2 * m, lc[2 + 2 * m], 1'b1, 1'b1, -10, 0, 1, 4);
      end
      chk_rec("t6_post", 9, lc[9], 1'b0, 1'b0, 0, 0, 0, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
